// File: rtl/trng_pkg.sv
// trng_pkg: width helpers and parameter-legality check shared by the TRNG entropy blocks
package trng_pkg;
  function automatic int div_w(int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction
  function automatic bit params_ok(int n_inv, int w, int div, int cutoff);
    return (n_inv % 2 == 1) && w >= 2 && div >= 1 && cutoff >= 2;
  endfunction
endpackage

// File: rtl/trng_ro_word_if.sv
// trng_ro_word_if: valid/ready word port of the TRNG
interface trng_ro_word_if #(parameter int W = 32);
  logic [W-1:0] data;
  logic valid;
  logic rdy;
  modport master(output data, valid, input rdy);
  modport slave(input data, valid, output rdy);
endinterface

// File: rtl/trng_health_rct.sv
// trng_health_rct: sticky repetition-count health test over strobed samples
module trng_health_rct import trng_pkg::*; #(parameter int RCT_CUTOFF = 16) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  input  logic sample_i,
  input  logic clear_i,
  output logic fail_o
);
  localparam int CW = cnt_w(RCT_CUTOFF);
  logic [CW-1:0] cnt_q, cnt_d;
  logic prev_q, prev_d, fail_q, fail_d;
  // a zero count means no history, so the next sample always starts a run of 1
  always_comb begin
    cnt_d = clear_i ? '0 : !strobe_i ? cnt_q :
            (cnt_q == '0 || sample_i != prev_q) ? CW'(1) :
            cnt_q + CW'(cnt_q != CW'(RCT_CUTOFF));
    prev_d = clear_i ? 1'b0 : strobe_i ? sample_i : prev_q;
    fail_d = fail_q || cnt_d == CW'(RCT_CUTOFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      prev_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      prev_q <= prev_d;
      fail_q <= fail_d;
    end
  end
  assign fail_o = fail_q;
endmodule

// File: rtl/trng_ro_cell.sv
// trng_ro_cell: N_INV-stage ring cell tapped at its last stage; the model advances once per clk
// so the netlist carries no combinational loop, IDX staggers the starting phase of each ring.
module trng_ro_cell #(parameter int N_INV = 3, IDX = 0) (
  input  logic clk,
  input  logic rst,
  output logic ro_o
);
  logic [N_INV-1:0] ring_q;
  always_ff @(posedge clk)
    ring_q <= rst ? N_INV'(IDX) : N_INV'({ring_q, ~ring_q[N_INV-1]});
  assign ro_o = ring_q[N_INV-1];
endmodule

// File: rtl/trng_ro_word.sv
// trng_ro_word: ring-oscillator TRNG packing sampled bits into W-bit valid/ready words.
// Define TRNG_VN_DEBIAS_EN to insert a von Neumann debiaser between sampler and collector.
module trng_ro_word import trng_pkg::*; #(
  parameter int N_INV = 3,
  parameter int N_RO = 32,
  parameter int W = 32,
  parameter int SAMPLE_DIV = 1,
  parameter int RCT_CUTOFF = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic tst_en_i,
  input  logic tst_bit_i,
  output logic fail_o,
  trng_ro_word_if.master bus
);
  localparam int DW = div_w(SAMPLE_DIV);
  localparam int NW = cnt_w(W);
  if (!params_ok(N_INV, W, SAMPLE_DIV, RCT_CUTOFF)) begin : g_bad_params
    $error("trng_ro_word: illegal parameter set");
  end
  logic [N_RO-1:0] ro;
  for (genvar i = 0; i < N_RO; i++) begin : g_ro
    trng_ro_cell #(.N_INV(N_INV), .IDX(i)) u_ro (.clk(clk), .rst(rst), .ro_o(ro[i]));
  end
  logic src, s1_q, s2_q, strobe, emit, bit_e, fail, vld, full, xfer, valid_q, valid_d;
  logic [DW-1:0] div_q, div_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [W-1:0] sr_q, sr_d, data_q, data_d;
  assign src = tst_en_i ? tst_bit_i : ^ro;
  assign strobe = en_i && div_q == DW'(SAMPLE_DIV - 1);
  assign div_d = (!en_i || strobe) ? '0 : div_q + DW'(1);
`ifdef TRNG_VN_DEBIAS_EN
  logic have_q, a_q;
  assign emit = strobe && have_q && a_q != s2_q;
  assign bit_e = a_q;
  always_ff @(posedge clk) begin
    have_q <= !rst && en_i && (have_q ^ strobe);
    a_q <= (rst || !en_i) ? 1'b0 : (strobe && !have_q) ? s2_q : a_q;
  end
`else
  assign emit = strobe;
  assign bit_e = s2_q;
`endif
  trng_health_rct #(.RCT_CUTOFF(RCT_CUTOFF)) u_rct (
    .clk(clk), .rst(rst), .strobe_i(strobe), .sample_i(s2_q), .clear_i(!en_i), .fail_o(fail)
  );
  assign vld = valid_q && !fail;
  assign full = cnt_q == NW'(W);
  assign xfer = full && (!vld || bus.rdy) && !fail;
  // a bit arriving on the transfer cycle starts the next word, keeping full throughput
  always_comb begin
    cnt_d = (fail || !en_i) ? '0 : xfer ? NW'(emit) : full ? cnt_q : cnt_q + NW'(emit);
    sr_d = (fail || !en_i) ? '0 : xfer ? W'(emit & bit_e) :
           (full || !emit) ? sr_q : {sr_q[W-2:0], bit_e};
    data_d = fail ? '0 : xfer ? sr_q : data_q;
    valid_d = !fail && (xfer || (valid_q && !bus.rdy));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      div_q <= '0;
      cnt_q <= '0;
      sr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_q <= src;
      s2_q <= s1_q;
      div_q <= div_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign bus.data = data_q;
  assign bus.valid = vld;
  assign fail_o = fail;
endmodule

// File: tb/tb_trng_ro_word.sv
// tb_trng_ro_word: directed bench for trng_ro_word through the test-injection path
module tb_trng_ro_word;
  localparam int W = 8;
`ifdef TRNG_VN_DEBIAS_EN
  localparam logic [7:0] DB_WORD = 8'h6C;
  localparam int DB_EDGE = 24;
`else
  localparam logic [7:0] DB_WORD = 8'h63;
  localparam int DB_EDGE = 10;
`endif
  logic clk = 0, rst = 1, en = 0, en4 = 0, tst_en = 1, tst_bit = 0, fail, fail4;
  int n_cmp = 0, n_bad = 0;
  trng_ro_word_if #(.W(W)) bus ();
  trng_ro_word_if #(.W(W)) bus4 ();
  trng_ro_word #(.N_INV(3), .N_RO(32), .W(W), .SAMPLE_DIV(1), .RCT_CUTOFF(16)) dut (
    .clk(clk), .rst(rst), .en_i(en), .tst_en_i(tst_en), .tst_bit_i(tst_bit), .fail_o(fail), .bus(bus)
  );
  trng_ro_word #(.N_INV(3), .N_RO(32), .W(W), .SAMPLE_DIV(4), .RCT_CUTOFF(16)) dut4 (
    .clk(clk), .rst(rst), .en_i(en4), .tst_en_i(tst_en), .tst_bit_i(tst_bit), .fail_o(fail4), .bus(bus4)
  );
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; en4 = 0; bus.rdy = 0; bus4.rdy = 0; tst_bit = 0;
    tick(2);
    rst = 0;
  endtask

  // bit i is shifted into the collector at edge k+i+2 (k = first edge); en opens in time for bit 0
  task automatic stream(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 2) en = 1;
      tst_bit = v[n-1-i];
      tick();
    end
  endtask

  task automatic test_reset();
    tst_en = 1; tst_bit = 1; en = 0; bus.rdy = 0; bus4.rdy = 0; rst = 1;
    tick(2);
    n_cmp++; if (bus.data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", bus.data); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail got %b want 0", fail); end
    n_cmp++; if (bus4.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid4 got %b want 0", bus4.valid); end
    rst = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid cyc %0d got %b want 0", i, bus.valid); end
    end
  endtask

  task automatic test_packing();
    do_reset();
    bus.rdy = 1;
    stream(32'h1F, 5);
    rst = 1; tick(); rst = 0; en = 0;
    stream(32'hB2, 8);
    tick(2);
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL pack_early got %b want 0", bus.valid); end
    tick();
    n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL pack_valid got %b want 1", bus.valid); end
    n_cmp++; if (bus.data !== 8'hB2) begin n_bad++; $display("FAIL pack_data got %h want b2", bus.data); end
    tick();
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL pack_pulse got %b want 0", bus.valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v = 16'hC33C;
    do_reset();
    bus.rdy = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) en = 1;
      tst_bit = i < 16 ? v[15-i] : i[0];
      tick();
      if (i == 10 || i == 18) begin
        n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid edge %0d got %b want 1", i, bus.valid); end
        n_cmp++; if (bus.data !== (i == 10 ? 8'hC3 : 8'h3C)) begin n_bad++; $display("FAIL b2b_data edge %0d got %h want %h", i, bus.data, i == 10 ? 8'hC3 : 8'h3C); end
      end else if (i == 11 || i == 17 || i == 19) begin
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap edge %0d got %b want 0", i, bus.valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stream(32'hB25AFF, 24);
    tst_bit = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.valid !== 1'b1 || bus.data !== 8'hB2) begin n_bad++; $display("FAIL bp_hold got %b/%h want 1/b2", bus.valid, bus.data); end
    end
    bus.rdy = 1;
    tick();
    n_cmp++; if (bus.valid !== 1'b1 || bus.data !== 8'h5A) begin n_bad++; $display("FAIL bp_next got %b/%h want 1/5a", bus.valid, bus.data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL bp_discard cyc %0d got %b want 0", i, bus.valid); end
    end
    en = 0;
  endtask

  task automatic test_debias();
    logic [21:0] v = 22'h18E6B5;
    do_reset();
    bus.rdy = 1;
    for (int i = 0; i <= DB_EDGE + 1; i++) begin
      if (i == 2) en = 1;
      tst_bit = i < 22 ? v[21-i] : i[0];
      tick();
      if (i == DB_EDGE) begin
        n_cmp++; if (bus.valid !== 1'b1 || bus.data !== DB_WORD) begin n_bad++; $display("FAIL debias_word got %b/%h want 1/%h", bus.valid, bus.data, DB_WORD); end
      end else begin
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL debias_idle edge %0d got %b want 0", i, bus.valid); end
      end
    end
  endtask

  task automatic test_health();
    do_reset();
    tst_bit = 1; bus.rdy = 1;
    tick(3);
    en = 1;
    tick(15);
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL rct_early got %b want 0", fail); end
    tick();
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL rct_trip got %b want 1", fail); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL rct_valid got %b want 0", bus.valid); end
    tick();
    n_cmp++; if (bus.data !== 8'h00) begin n_bad++; $display("FAIL rct_clear got %h want 00", bus.data); end
    tst_bit = 0;
    for (int i = 0; i < 12; i++) begin
      tst_bit = ~tst_bit;
      tick();
      n_cmp++; if (fail !== 1'b1 || bus.valid !== 1'b0) begin n_bad++; $display("FAIL rct_sticky cyc %0d got %b/%b want 1/0", i, fail, bus.valid); end
    end
    rst = 1; tick(); rst = 0; en = 0;
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL rct_rst got %b want 0", fail); end
  endtask

  task automatic test_divider();
    logic [7:0] v = 8'h9D;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) en4 = 1;
      tst_bit = (c % 4 == 2) ? v[7-(c+1)/4] : ~v[7-(c+1)/4];
      tick();
    end
    tick();
    n_cmp++; if (bus4.valid !== 1'b0) begin n_bad++; $display("FAIL div_e31 got %b want 0", bus4.valid); end
    tick();
    n_cmp++; if (bus4.valid !== 1'b0) begin n_bad++; $display("FAIL div_e32 got %b want 0", bus4.valid); end
    tick();
    n_cmp++; if (bus4.valid !== 1'b1 || bus4.data !== 8'h9D) begin n_bad++; $display("FAIL div_word got %b/%h want 1/9d", bus4.valid, bus4.data); end
    tick(3);
    n_cmp++; if (bus4.valid !== 1'b1 || bus4.data !== 8'h9D) begin n_bad++; $display("FAIL div_hold got %b/%h want 1/9d", bus4.valid, bus4.data); end
    en4 = 0;
  endtask

  initial begin
    test_reset();
    test_packing();
    test_back_to_back();
    test_backpressure();
    test_debias();
    test_health();
    test_divider();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
